mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
Game-round controller for the Whac-A-Mole datapath. It samples the free-running random-value generator (values 200..1223) to decide each mole's pop-up delay, which mole appears, and how long it stays up. It then judges player hits and counts rounds. It sits between the rng instance, the debounced button inputs, and the LED/score logic.

Parameters:
N_MOLES, 8, number of moles/buttons; must be a power of 2, 2..16
RAND_W, 11, width of random_value input
ROUNDS, 30, moles per game
MIN_UP_MS, 300, minimum mole up-time in ms
UP_SHIFT, 1, right-shift applied to random_value for up-time

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ms_tick  input  1  one-cycle pulse every 1 ms, synchronous to clk
random_value  input  RAND_W  current rng output, stable between clk edges
start  input  1  one-cycle pulse; begins a game from IDLE or DONE
abort  input  1  level; forces return to IDLE
hit_btn  input  N_MOLES  debounced one-cycle button pulses, one bit per mole
mole_leds  output  N_MOLES  one-hot active mole; all zero when no mole is up
hit_pulse  output  1  one cycle, correct mole hit
miss_pulse  output  1  one cycle, mole timed out unhit
whiff_pulse  output  1  one cycle, wrong button pressed while a mole is up
round_cnt  output  $clog2(ROUNDS+1)  completed rounds in the current game
busy  output  1  high in WAIT or UP
done  output  1  high in DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE; mole_leds=0; all pulses 0; round_cnt=0; busy=0; done=0; timer=0; last_idx=0.
- States: IDLE, WAIT, UP, DONE. The state register and all outputs are registered.
- IDLE: on start -> WAIT; round_cnt<=0; timer<=random_value (sampled that cycle).
- WAIT:
  - On each ms_tick, timer decrements.
  - On the ms_tick where timer==1 -> UP. A delay of V therefore equals exactly V ticks.
  - On the transition: idx = random_value[log2(N_MOLES)-1:0]. If idx==last_idx, use (idx+1) mod N_MOLES. No mole repeats back-to-back.
  - Also on the transition: mole_leds<=one-hot(idx); last_idx<=idx; timer<=(random_value>>UP_SHIFT)+MIN_UP_MS.
- UP, evaluated per cycle, in priority order:
  - hit_btn[active]=1: hit_pulse=1. This takes priority even if timer expires or other buttons press in the same cycle.
  - Otherwise, any other hit_btn bit set: whiff_pulse=1. The mole stays up and the timer is unaffected.
  - Otherwise, ms_tick with timer==1: miss_pulse=1.
- On a hit or miss:
  - mole_leds<=0; round_cnt increments.
  - If the new round_cnt==ROUNDS -> DONE; else -> WAIT with timer<=random_value.
- Pulses assert in the cycle after the triggering input (one-cycle registered latency). mole_leds clears in that same cycle.
- DONE: done=1, mole_leds=0, round_cnt held. On start -> WAIT with round_cnt<=0 (same as IDLE start).
- start is ignored in WAIT and UP.
- abort (any state) -> IDLE next cycle; mole_leds=0; round_cnt<=0; no pulse is emitted. abort overrides start and hit.
- Button pulses in IDLE, WAIT, or DONE are ignored; no whiff is reported.
- Width rules:
  - Timer is RAND_W+1 bits. Up-time max = (1223>>1)+300 = 911, which fits.
  - Timer never loads 0 because the input is ≥200. A timer of 0 is unreachable; treat it as expiry on the next ms_tick.
- Ticks only decrement the timer in WAIT and UP. ms_tick and start in the same cycle: the load wins; no decrement occurs in the load cycle.
- Reset mid-game: state returns to IDLE immediately and asynchronously; LEDs go off.

Test Plan:
1. Reset with rst_n=0 mid-UP -> mole_leds=0, busy=0, round_cnt=0, immediately without clk edge.
2. Hold random_value=200, pulse start, issue ms_ticks -> UP entered on the 200th tick; mole index 200[2:0]=0 equals last_idx 0 -> mole 1, mole_leds=8'b00000010; up-timer=400.
3. In UP, pulse hit_btn=8'b00000010 -> hit_pulse for one cycle, mole_leds=0, round_cnt=1, state WAIT.
4. In UP with up-timer=400, no buttons -> miss_pulse on the 400th tick. In the same UP, hit_btn=8'b00000100 gives whiff_pulse only and the mole stays lit.
5. In UP, hit_btn[active] and the final expiring ms_tick in the same cycle -> hit_pulse=1, miss_pulse=0.
6. ROUNDS=3, run three hits -> done=1, busy=0, round_cnt=3. Start -> round_cnt=0, WAIT. An abort in WAIT -> IDLE, no pulses.

Source files
------------

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - Whac-A-Mole round controller: random pop-up delay, mole choice, up-time and hit judging.
module mole_scheduler #(
  parameter int N_MOLES   = 8,
  parameter int RAND_W    = 11,
  parameter int ROUNDS    = 30,
  parameter int MIN_UP_MS = 300,
  parameter int UP_SHIFT  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ms_tick,
  input  logic [RAND_W-1:0]            random_value,
  input  logic                         start,
  input  logic                         abort,
  input  logic [N_MOLES-1:0]           hit_btn,
  output logic [N_MOLES-1:0]           mole_leds,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic                         whiff_pulse,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(N_MOLES);
  localparam int TW    = RAND_W + 1;
  localparam int CW    = $clog2(ROUNDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [TW-1:0]      timer;
  logic [IDX_W-1:0]   last_idx;

  logic [IDX_W-1:0]   raw_idx;
  logic [IDX_W-1:0]   next_idx;
  logic [N_MOLES-1:0] next_leds;
  logic [TW-1:0]      up_time;
  logic [TW-1:0]      delay_time;
  logic [CW-1:0]      round_next;
  logic               round_last;
  logic               expire;
  logic               hit_any;
  logic               whiff_any;

  always_comb begin
    raw_idx    = random_value[IDX_W-1:0];
    // Bump to the neighbour so the same mole never pops twice in a row.
    next_idx   = (raw_idx == last_idx) ? raw_idx + IDX_W'(1) : raw_idx;
    next_leds  = '0;
    next_leds[next_idx] = 1'b1;
    up_time    = TW'(random_value >> UP_SHIFT) + TW'(MIN_UP_MS);
    delay_time = TW'(random_value);
    round_next = round_cnt + CW'(1);
    round_last = (round_next == CW'(ROUNDS));
    // A zero timer cannot be loaded, but if seen it expires on the next tick.
    expire     = ms_tick && (timer <= TW'(1));
    hit_any    = |(hit_btn & mole_leds);
    whiff_any  = |(hit_btn & ~mole_leds);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      last_idx    <= '0;
      mole_leds   <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      whiff_pulse <= 1'b0;
      round_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      whiff_pulse <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        mole_leds <= '0;
        round_cnt <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state     <= S_WAIT;
              round_cnt <= '0;
              timer     <= delay_time;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
          S_WAIT: begin
            if (expire) begin
              state     <= S_UP;
              mole_leds <= next_leds;
              last_idx  <= next_idx;
              timer     <= up_time;
            end else if (ms_tick) begin
              timer <= timer - TW'(1);
            end
          end
          S_UP: begin
            // Correct button beats expiry and stray buttons; a whiff freezes the timer that cycle.
            if (hit_any || (!whiff_any && expire)) begin
              hit_pulse  <= hit_any;
              miss_pulse <= !hit_any;
              mole_leds  <= '0;
              round_cnt  <= round_next;
              if (round_last) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_WAIT;
                timer <= delay_time;
              end
            end else if (whiff_any) begin
              whiff_pulse <= 1'b1;
            end else if (ms_tick) begin
              timer <= timer - TW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - Self-checking bench for mole_scheduler with directed and randomized games.
module tb_mole_scheduler;

  localparam int N  = 8;
  localparam int RW = 11;
  localparam int RN = 3;
  localparam int CW = $clog2(RN + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ms_tick = 1'b0;
  logic [RW-1:0] random_value = RW'(200);
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  hit_btn = '0;
  logic [N-1:0]  mole_leds;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          whiff_pulse;
  logic [CW-1:0] round_cnt;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int m_last = 0;

  mole_scheduler #(
    .N_MOLES(N), .RAND_W(RW), .ROUNDS(RN), .MIN_UP_MS(300), .UP_SHIFT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .random_value(random_value),
    .start(start), .abort(abort), .hit_btn(hit_btn), .mole_leds(mole_leds),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .whiff_pulse(whiff_pulse),
    .round_cnt(round_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rrv();
    return RW'(200 + $urandom_range(0, 1023));
  endfunction

  task automatic apply(input logic tk, input logic [N-1:0] btn, input logic st, input logic ab);
    ms_tick = tk; hit_btn = btn; start = st; abort = ab;
    @(posedge clk); #1;
    ms_tick = 1'b0; hit_btn = '0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hit_btn = '1; start = 1'b1; ms_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mole_leds !== '0) begin failures++; $display("FAIL reset_leds got=%h exp=0", mole_leds); end
    checks++; if ({hit_pulse, miss_pulse, whiff_pulse} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {hit_pulse, miss_pulse, whiff_pulse}); end
    checks++; if (round_cnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_status cnt=%0d busy=%b done=%b exp 0/0/0", round_cnt, busy, done); end
    hit_btn = '0; start = 1'b0; ms_tick = 1'b0;
    rst_n = 1'b1;
    apply(1'b0, 8'hFF, 1'b0, 1'b0);
    checks++; if (whiff_pulse !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_buttons whiff=%b busy=%b exp 0/0", whiff_pulse, busy); end
  endtask

  task automatic test_first_mole();
    random_value = RW'(200);
    apply(1'b1, '0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || round_cnt !== '0) begin failures++; $display("FAIL start_wait busy=%b cnt=%0d exp 1/0", busy, round_cnt); end
    ticks(199);
    checks++; if (mole_leds !== '0) begin failures++; $display("FAIL wait_199 leds=%h exp=00", mole_leds); end
    apply(1'b1, '0, 1'b0, 1'b0);
    checks++; if (mole_leds !== 8'h02) begin failures++; $display("FAIL first_mole leds=%h exp=02", mole_leds); end
  endtask

  task automatic test_hit();
    apply(1'b0, 8'h02, 1'b0, 1'b0);
    checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || whiff_pulse !== 1'b0) begin failures++; $display("FAIL hit_pulse got=%b%b%b exp=100", hit_pulse, miss_pulse, whiff_pulse); end
    checks++; if (mole_leds !== '0 || round_cnt !== CW'(1) || busy !== 1'b1) begin failures++; $display("FAIL hit_state leds=%h cnt=%0d busy=%b exp 00/1/1", mole_leds, round_cnt, busy); end
    apply(1'b0, '0, 1'b0, 1'b0);
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b exp=0", hit_pulse); end
  endtask

  task automatic test_whiff_miss();
    ticks(199);
    apply(1'b1, '0, 1'b0, 1'b0);
    checks++; if (mole_leds !== 8'h01) begin failures++; $display("FAIL second_mole leds=%h exp=01", mole_leds); end
    apply(1'b0, 8'h04, 1'b0, 1'b0);
    checks++; if (whiff_pulse !== 1'b1 || hit_pulse !== 1'b0 || mole_leds !== 8'h01) begin failures++; $display("FAIL whiff whiff=%b hit=%b leds=%h exp 1/0/01", whiff_pulse, hit_pulse, mole_leds); end
    ticks(399);
    checks++; if (miss_pulse !== 1'b0 || mole_leds !== 8'h01) begin failures++; $display("FAIL up_399 miss=%b leds=%h exp 0/01", miss_pulse, mole_leds); end
    apply(1'b1, '0, 1'b0, 1'b0);
    checks++; if (miss_pulse !== 1'b1 || mole_leds !== '0 || round_cnt !== CW'(2)) begin failures++; $display("FAIL miss miss=%b leds=%h cnt=%0d exp 1/00/2", miss_pulse, mole_leds, round_cnt); end
  endtask

  task automatic test_hit_beats_expiry();
    ticks(200);
    checks++; if (mole_leds !== 8'h02) begin failures++; $display("FAIL third_mole leds=%h exp=02", mole_leds); end
    ticks(399);
    apply(1'b1, 8'h12, 1'b0, 1'b0);
    checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || whiff_pulse !== 1'b0) begin failures++; $display("FAIL hit_vs_expiry got=%b%b%b exp=100", hit_pulse, miss_pulse, whiff_pulse); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || round_cnt !== CW'(3) || mole_leds !== '0) begin failures++; $display("FAIL game_done done=%b busy=%b cnt=%0d leds=%h exp 1/0/3/00", done, busy, round_cnt, mole_leds); end
  endtask

  task automatic test_restart_abort();
    apply(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++; if (whiff_pulse !== 1'b0 || done !== 1'b1 || round_cnt !== CW'(3)) begin failures++; $display("FAIL done_hold whiff=%b done=%b cnt=%0d exp 0/1/3", whiff_pulse, done, round_cnt); end
    random_value = RW'(200);
    apply(1'b0, '0, 1'b1, 1'b0);
    checks++; if (round_cnt !== '0 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL restart cnt=%0d busy=%b done=%b exp 0/1/0", round_cnt, busy, done); end
    ticks(5);
    apply(1'b1, 8'hFF, 1'b1, 1'b1);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || round_cnt !== '0 || mole_leds !== '0) begin failures++; $display("FAIL abort busy=%b done=%b cnt=%0d leds=%h exp 0/0/0/00", busy, done, round_cnt, mole_leds); end
    checks++; if ({hit_pulse, miss_pulse, whiff_pulse} !== 3'b000) begin failures++; $display("FAIL abort_pulses got=%b exp=000", {hit_pulse, miss_pulse, whiff_pulse}); end
  endtask

  task automatic test_random_games();
    logic [RW-1:0] rv;
    logic [N-1:0]  btn;
    logic [N-1:0]  exp_leds;
    logic          tk, plan_hit, fin, e_hit, e_miss, e_whiff;
    int            delay, up, t, k, mole, guard, cnt;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    m_last = 0;
    mole = 0;
    rv = RW'(200);
    for (int g = 0; g < 3; g++) begin
      rv = rrv();
      random_value = rv;
      apply(1'b0, '0, 1'b1, 1'b0);
      checks++; if (busy !== 1'b1 || round_cnt !== '0) begin failures++; $display("FAIL rnd_start g=%0d busy=%b cnt=%0d exp 1/0", g, busy, round_cnt); end
      delay = int'(rv);
      cnt = 0;
      for (int r = 0; r < RN; r++) begin
        t = 0; guard = 0;
        while (t < delay && guard < 5000) begin
          guard++;
          tk = ($urandom_range(0, 3) != 0);
          rv = rrv();
          random_value = rv;
          btn = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
          apply(tk, btn, ($urandom_range(0, 15) == 0), 1'b0);
          if (tk) t++;
          exp_leds = '0;
          if (t == delay) begin
            mole = int'(rv) % N;
            if (mole == m_last) mole = (mole + 1) % N;
            m_last = mole;
            exp_leds = N'(1) << mole;
          end
          checks++; if (mole_leds !== exp_leds) begin failures++; $display("FAIL rnd_wait_leds t=%0d got=%h exp=%h", t, mole_leds, exp_leds); end
          checks++; if ({hit_pulse, miss_pulse, whiff_pulse} !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL rnd_wait_quiet pulses=%b busy=%b exp 000/1", {hit_pulse, miss_pulse, whiff_pulse}, busy); end
        end
        if (t < delay) begin
          checks++; failures++; $display("FAIL rnd_wait_timeout t=%0d delay=%0d", t, delay);
          return;
        end
        up = int'(rv) / 2 + 300;
        plan_hit = 1'($urandom_range(0, 1));
        k = $urandom_range(0, up - 1);
        t = 0; fin = 1'b0; guard = 0;
        while (!fin && guard < 5000) begin
          guard++;
          e_hit = 1'b0; e_miss = 1'b0; e_whiff = 1'b0;
          rv = rrv();
          random_value = rv;
          if (plan_hit && t == k) begin
            tk = 1'($urandom_range(0, 1));
            btn = (N'(1) << mole) | (($urandom_range(0, 1) == 1) ? N'($urandom) : '0);
            e_hit = 1'b1; fin = 1'b1;
          end else if ($urandom_range(0, 7) == 0) begin
            tk = 1'b0;
            btn = N'(1) << ((mole + 1 + $urandom_range(0, N - 2)) % N);
            e_whiff = 1'b1;
          end else begin
            tk = ($urandom_range(0, 3) != 0);
            btn = '0;
            if (tk) t++;
            if (t == up) begin e_miss = 1'b1; fin = 1'b1; end
          end
          apply(tk, btn, 1'b0, 1'b0);
          exp_leds = fin ? '0 : (N'(1) << mole);
          checks++; if ({hit_pulse, miss_pulse, whiff_pulse} !== {e_hit, e_miss, e_whiff}) begin failures++; $display("FAIL rnd_up_pulses t=%0d up=%0d got=%b exp=%b", t, up, {hit_pulse, miss_pulse, whiff_pulse}, {e_hit, e_miss, e_whiff}); end
          checks++; if (mole_leds !== exp_leds) begin failures++; $display("FAIL rnd_up_leds got=%h exp=%h", mole_leds, exp_leds); end
        end
        if (!fin) begin
          checks++; failures++; $display("FAIL rnd_up_timeout t=%0d up=%0d", t, up);
          return;
        end
        cnt++;
        checks++; if (round_cnt !== CW'(cnt)) begin failures++; $display("FAIL rnd_round_cnt got=%0d exp=%0d", round_cnt, cnt); end
        checks++; if (done !== (cnt == RN) || busy !== (cnt != RN)) begin failures++; $display("FAIL rnd_status done=%b busy=%b exp_done=%0d", done, busy, cnt == RN); end
        delay = int'(rv);
      end
    end
  endtask

  task automatic test_async_reset_mid_up();
    random_value = RW'(200);
    apply(1'b0, '0, 1'b1, 1'b0);
    ticks(200);
    checks++; if (mole_leds === '0) begin failures++; $display("FAIL pre_reset_up leds=%h exp nonzero", mole_leds); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mole_leds !== '0 || busy !== 1'b0 || round_cnt !== '0) begin failures++; $display("FAIL async_reset leds=%h busy=%b cnt=%0d exp 00/0/0", mole_leds, busy, round_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_mole();
    test_hit();
    test_whiff_miss();
    test_hit_beats_expiry();
    test_restart_abort();
    test_random_games();
    test_async_reset_mid_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
